// File: rtl/cache_arb_if.sv
// ============================================================================
// cache_arb_if : requester and cache-side signal bundle for cache_arb
// Revision     : 1.0
// ============================================================================
`default_nettype none

interface cache_arb_if #(
    parameter int AW = 8,
    parameter int DW = 8
);
    logic          req0, req1;
    logic          rw0, rw1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          ack0, ack1;
    logic [DW-1:0] rdata;
    logic          busy;
    logic          c_enab;
    logic          c_rw;
    logic [AW-1:0] c_addr;
    logic [DW-1:0] c_data;
    logic [DW-1:0] c_data_out;
    logic          c_hit;
    logic [7:0]    hit_cnt, miss_cnt;

    modport slave (
        input  req0, req1, rw0, rw1, addr0, addr1, wdata0, wdata1,
        input  c_data_out, c_hit,
        output ack0, ack1, rdata, busy, c_enab, c_rw, c_addr, c_data,
        output hit_cnt, miss_cnt
    );

    modport master (
        output req0, req1, rw0, rw1, addr0, addr1, wdata0, wdata1,
        output c_data_out, c_hit,
        input  ack0, ack1, rdata, busy, c_enab, c_rw, c_addr, c_data,
        input  hit_cnt, miss_cnt
    );
endinterface

`default_nettype wire

// File: rtl/cache_arb.sv
// ============================================================================
// cache_arb : two-port round-robin arbiter in front of a single cache port
// Revision  : 1.0
// ============================================================================
`default_nettype none

module cache_arb #(
    parameter int AW       = 8,
    parameter int DW       = 8,
    parameter int ACC_CYC  = 2,
    parameter int MISS_CYC = 4
) (
    input  wire logic    clk,
    input  wire logic    clr,
    cache_arb_if.slave   bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        MISS  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    cnt_q, cnt_d;
    logic          owner_q, owner_d;
    logic          last_owner_q, last_owner_d;
    logic          ack0_q, ack0_d, ack1_q, ack1_d;
    logic          busy_q, busy_d;
    logic          c_enab_q, c_enab_d;
    logic          c_rw_q, c_rw_d;
    logic [AW-1:0] c_addr_q, c_addr_d;
    logic [DW-1:0] c_data_q, c_data_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic [7:0]    hit_cnt_q, hit_cnt_d;
    logic [7:0]    miss_cnt_q, miss_cnt_d;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        ack0_d       = 1'b0;
        ack1_d       = 1'b0;
        c_enab_d     = c_enab_q;
        c_rw_d       = c_rw_q;
        c_addr_d     = c_addr_q;
        c_data_d     = c_data_q;
        rdata_d      = rdata_q;
        hit_cnt_d    = hit_cnt_q;
        miss_cnt_d   = miss_cnt_q;

        case (state_q)
            IDLE: begin
                if (bus.req0 || bus.req1) begin
                    // On a tie the port that did not own the last access wins.
                    owner_d  = bus.req1 & (~bus.req0 | ~last_owner_q);
                    c_rw_d   = owner_d ? bus.rw1    : bus.rw0;
                    c_addr_d = owner_d ? bus.addr1  : bus.addr0;
                    c_data_d = owner_d ? bus.wdata1 : bus.wdata0;
                    c_enab_d = 1'b1;
                    cnt_d    = 8'd0;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                if (cnt_q == 8'(ACC_CYC - 1)) begin
                    cnt_d = 8'd0;
                    if (bus.c_hit) begin
                        state_d   = DONE;
                        c_enab_d  = 1'b0;
                        ack0_d    = ~owner_q;
                        ack1_d    = owner_q;
                        hit_cnt_d = (hit_cnt_q == 8'hFF) ? hit_cnt_q : hit_cnt_q + 8'd1;
                        if (!c_rw_q) rdata_d = bus.c_data_out;
                    end else begin
                        state_d    = MISS;
                        miss_cnt_d = (miss_cnt_q == 8'hFF) ? miss_cnt_q : miss_cnt_q + 8'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            MISS: begin
                if (cnt_q == 8'(MISS_CYC - 1)) begin
                    cnt_d    = 8'd0;
                    state_d  = DONE;
                    c_enab_d = 1'b0;
                    ack0_d   = ~owner_q;
                    ack1_d   = owner_q;
                    if (!c_rw_q) rdata_d = bus.c_data_out;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            DONE: begin
                last_owner_d = owner_q;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q      <= IDLE;
            cnt_q        <= 8'd0;
            owner_q      <= 1'b0;
            last_owner_q <= 1'b1;
            ack0_q       <= 1'b0;
            ack1_q       <= 1'b0;
            busy_q       <= 1'b0;
            c_enab_q     <= 1'b0;
            c_rw_q       <= 1'b0;
            c_addr_q     <= '0;
            c_data_q     <= '0;
            rdata_q      <= '0;
            hit_cnt_q    <= 8'd0;
            miss_cnt_q   <= 8'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            ack0_q       <= ack0_d;
            ack1_q       <= ack1_d;
            busy_q       <= busy_d;
            c_enab_q     <= c_enab_d;
            c_rw_q       <= c_rw_d;
            c_addr_q     <= c_addr_d;
            c_data_q     <= c_data_d;
            rdata_q      <= rdata_d;
            hit_cnt_q    <= hit_cnt_d;
            miss_cnt_q   <= miss_cnt_d;
        end
    end

    assign bus.ack0     = ack0_q;
    assign bus.ack1     = ack1_q;
    assign bus.busy     = busy_q;
    assign bus.c_enab   = c_enab_q;
    assign bus.c_rw     = c_rw_q;
    assign bus.c_addr   = c_addr_q;
    assign bus.c_data   = c_data_q;
    assign bus.rdata    = rdata_q;
    assign bus.hit_cnt  = hit_cnt_q;
    assign bus.miss_cnt = miss_cnt_q;
endmodule

`default_nettype wire

// File: tb/tb_cache_arb.sv
// ============================================================================
// tb_cache_arb : directed self-checking bench for cache_arb
// Revision     : 1.0
// ============================================================================
`default_nettype none

module tb_cache_arb;
    logic clk;
    logic clr;
    int   n_checks;
    int   n_fail;
    int   overlap_n;

    // Results captured by observe()
    int          o_en, o_busy_n, o_ack0_at, o_ack1_at, o_ack0_n, o_ack1_n;
    logic        o_rw;
    logic [7:0]  o_addr, o_data;

    cache_arb_if #(.AW(8), .DW(8)) bus ();

    cache_arb #(.AW(8), .DW(8), .ACC_CYC(2), .MISS_CYC(4)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (bus.ack0 && bus.ack1) overlap_n++;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        clr = 1'b0;
        repeat (2) @(negedge clk);
        clr = 1'b1;
    endtask

    // Watches ncyc negedges; idx 1 is the first negedge after the arbitration edge.
    task automatic observe(input int ncyc, input bit drop_on_ack, input int drop0_idx);
        o_en = 0; o_busy_n = 0; o_ack0_at = -1; o_ack1_at = -1; o_ack0_n = 0; o_ack1_n = 0;
        for (int i = 1; i <= ncyc; i++) begin
            @(negedge clk);
            if (i == 1) begin
                o_rw = bus.c_rw; o_addr = bus.c_addr; o_data = bus.c_data;
            end
            if (bus.c_enab) o_en++;
            if (bus.busy)   o_busy_n++;
            if (bus.ack0) begin
                if (o_ack0_at < 0) o_ack0_at = i;
                o_ack0_n++;
                if (drop_on_ack) bus.req0 = 1'b0;
            end
            if (bus.ack1) begin
                if (o_ack1_at < 0) o_ack1_at = i;
                o_ack1_n++;
                if (drop_on_ack) bus.req1 = 1'b0;
            end
            if (i == drop0_idx) bus.req0 = 1'b0;
        end
    endtask

    initial begin
        int order[$];
        int exp_ord[4];
        int low_n, run2, acks;
        bit prev_low;

        n_checks = 0; n_fail = 0; overlap_n = 0;
        clr = 1'b0;
        bus.req0 = 0; bus.req1 = 0; bus.rw0 = 0; bus.rw1 = 0;
        bus.addr0 = 0; bus.addr1 = 0; bus.wdata0 = 0; bus.wdata1 = 0;
        bus.c_hit = 0; bus.c_data_out = 0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_busy", bus.busy, 0);
        check("rst_ack", {bus.ack1, bus.ack0}, 0);
        check("rst_c_enab", bus.c_enab, 0);
        check("rst_c_bus", {bus.c_rw, bus.c_addr, bus.c_data}, 0);
        check("rst_rdata", bus.rdata, 0);
        check("rst_cnts", {bus.hit_cnt, bus.miss_cnt}, 0);
        clr = 1'b1;

        // Read hit on port 0
        bus.req0 = 1; bus.rw0 = 0; bus.addr0 = 8'h04; bus.c_hit = 1; bus.c_data_out = 8'h04;
        observe(8, 1'b1, -1);
        check("t1_enab_cycles", o_en, 2);
        check("t1_ack0_latency", o_ack0_at, 3);
        check("t1_ack0_count", o_ack0_n, 1);
        check("t1_ack1_count", o_ack1_n, 0);
        check("t1_c_rw_addr", {o_rw, o_addr}, {1'b0, 8'h04});
        check("t1_rdata", bus.rdata, 8'h04);
        check("t1_hit_cnt", bus.hit_cnt, 1);

        // Write miss on port 1
        bus.req1 = 1; bus.rw1 = 1; bus.addr1 = 8'h80; bus.wdata1 = 8'h07;
        bus.c_hit = 0; bus.c_data_out = 8'hEE;
        observe(12, 1'b1, -1);
        check("t2_enab_cycles", o_en, 6);
        check("t2_ack1_latency", o_ack1_at, 7);
        check("t2_ack0_count", o_ack0_n, 0);
        check("t2_c_fields", {o_rw, o_addr, o_data}, {1'b1, 8'h80, 8'h07});
        check("t2_miss_cnt", bus.miss_cnt, 1);
        check("t2_hit_cnt", bus.hit_cnt, 1);
        check("t2_rdata_held", bus.rdata, 8'h04);

        // Both ports held from reset: alternate grants
        reset_pulse();
        bus.req0 = 1; bus.req1 = 1; bus.rw0 = 0; bus.rw1 = 0;
        bus.c_hit = 1; bus.c_data_out = 8'h5A;
        low_n = 0; run2 = 0; prev_low = 0;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            if (bus.ack0) order.push_back(0);
            if (bus.ack1) order.push_back(1);
            if (!bus.busy) begin
                low_n++;
                if (prev_low) run2++;
            end
            prev_low = !bus.busy;
            if (order.size() == 4) begin bus.req0 = 0; bus.req1 = 0; end
        end
        exp_ord = '{0, 1, 0, 1};
        check("t3_grant_count", order.size(), 4);
        for (int k = 0; k < 4; k++)
            check($sformatf("t3_grant%0d", k), (k < order.size()) ? order[k] : 99, exp_ord[k]);
        check("t3_busy_low_cycles", low_n, 4);
        check("t3_busy_low_runs", run2, 0);
        check("t3_rdata", bus.rdata, 8'h5A);
        check("t3_hit_cnt", bus.hit_cnt, 4);

        // Reset asserted during MISS
        reset_pulse();
        bus.req0 = 1; bus.rw0 = 0; bus.addr0 = 8'h33; bus.c_hit = 0;
        repeat (4) @(negedge clk);
        check("t4_pre_enab", {bus.busy, bus.c_enab}, 2'b11);
        check("t4_pre_miss", bus.miss_cnt, 1);
        clr = 1'b0;
        #1;
        check("t4_async_busy_enab", {bus.busy, bus.c_enab}, 0);
        check("t4_async_c_bus", {bus.c_rw, bus.c_addr, bus.c_data}, 0);
        check("t4_async_cnts", {bus.hit_cnt, bus.miss_cnt}, 0);
        bus.req0 = 0;
        repeat (2) @(negedge clk);
        clr = 1'b1;
        observe(8, 1'b0, -1);
        check("t4_no_ack", o_ack0_n + o_ack1_n, 0);
        check("t4_idle", o_busy_n, 0);
        check("t4_cnts", {bus.hit_cnt, bus.miss_cnt}, 0);

        // req0 dropped one cycle into ISSUE
        bus.req0 = 1; bus.rw0 = 0; bus.addr0 = 8'h10; bus.c_hit = 1; bus.c_data_out = 8'h3C;
        observe(12, 1'b0, 1);
        check("t5_ack0_count", o_ack0_n, 1);
        check("t5_ack0_latency", o_ack0_at, 3);
        check("t5_busy_cycles", o_busy_n, 3);
        check("t5_rdata", bus.rdata, 8'h3C);
        check("t5_hit_cnt", bus.hit_cnt, 1);

        // 300 consecutive hits saturate hit_cnt
        reset_pulse();
        bus.req0 = 1; bus.c_hit = 1;
        acks = 0;
        for (int i = 0; i < 1400 && acks < 300; i++) begin
            @(negedge clk);
            if (bus.ack0) acks++;
            if (acks == 300) bus.req0 = 0;
        end
        bus.req0 = 0;
        repeat (3) @(negedge clk);
        check("t6_acks", acks, 300);
        check("t6_hit_sat", bus.hit_cnt, 255);
        check("t6_miss_cnt", bus.miss_cnt, 0);
        check("ack_overlap", overlap_n, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

`default_nettype wire
